pe_inst_sequencer: RTL and testbench

//   Static-schedule instruction sequencer for one SCGRA PE. Fetches instruction words from a local

---
 rtl/pe_inst_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pe_inst_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_inst_sequencer.sv
// Static-schedule instruction sequencer for one SCGRA processing element.
// Fetches one instruction word per cycle from a synchronous instruction RAM,
// issues data-memory read addresses and the ALU opcode so that operands and
// opcode meet at the ALU, and delays the write-back enable/address by the ALU
// latency. A Start/Done handshake frames each program run.
module pe_inst_sequencer #(
    parameter int INST_AW = 10,
    parameter int DAW     = 8,
    parameter int ALU_LAT = 8
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               Start,
    input  logic [INST_AW-1:0] Start_Addr,
    output logic               Busy,
    output logic               Done,
    output logic [INST_AW-1:0] Inst_Addr,
    input  logic [4*DAW+5:0]   Inst_Data,
    output logic [DAW-1:0]     Rd_Addr0,
    output logic [DAW-1:0]     Rd_Addr1,
    output logic [DAW-1:0]     Rd_Addr2,
    output logic [3:0]         OP_Sel,
    output logic               Wr_En,
    output logic [DAW-1:0]     Wr_Addr
);

    localparam int IW = 4*DAW + 6;
    localparam logic [INST_AW-1:0] PC_MAX = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    logic [INST_AW-1:0] pc;

    // fetch stage tags: p0 = address in PC, p1 = word on Inst_Data
    logic               fetch_vld_p0;
    logic               fetch_vld_p1;
    logic               pc_end_p1;

    // decode stage
    logic               dec_vld_p2;
    logic               dec_wb_p2;
    logic               dec_last_p2;
    logic [3:0]         dec_op_p2;
    logic [DAW-1:0]     dec_dst_p2;

    // issue stage (opcode at ALU inputs)
    logic               iss_vld_p3;
    logic               iss_wb_p3;
    logic               iss_last_p3;
    logic [DAW-1:0]     iss_dst_p3;

    // write-back delay line, last entry drives the data-memory write port
    logic [ALU_LAT-1:0] wb_en_dl;
    logic [ALU_LAT-1:0] wb_last_dl;
    logic [DAW-1:0]     wb_dst_dl [ALU_LAT];

    // instruction word fields
    logic [3:0]         word_op;
    logic [DAW-1:0]     word_src0;
    logic [DAW-1:0]     word_src1;
    logic [DAW-1:0]     word_src2;
    logic [DAW-1:0]     word_dst;
    logic               word_wb;
    logic               word_last;
    logic               word_vld;
    logic               last_hit;

    assign word_op   = Inst_Data[3:0];
    assign word_src0 = Inst_Data[4 +: DAW];
    assign word_src1 = Inst_Data[4 + DAW +: DAW];
    assign word_src2 = Inst_Data[4 + 2*DAW +: DAW];
    assign word_dst  = Inst_Data[4 + 3*DAW +: DAW];
    assign word_wb   = Inst_Data[IW-2];
    assign word_last = Inst_Data[IW-1];

    // A word fetched from the top address ends the program even without its last bit.
    assign word_vld  = fetch_vld_p1 && (state == FETCH);
    assign last_hit  = word_vld && (word_last || pc_end_p1);

    assign Inst_Addr = pc;
    assign Wr_En     = wb_en_dl[ALU_LAT-1];
    assign Wr_Addr   = wb_dst_dl[ALU_LAT-1];

    // Control FSM: start handshake, PC advance, fetch tags, squash and Done.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            pc           <= '0;
            fetch_vld_p0 <= 1'b0;
            fetch_vld_p1 <= 1'b0;
            pc_end_p1    <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            Done         <= 1'b0;
            fetch_vld_p1 <= fetch_vld_p0;
            pc_end_p1    <= (pc == PC_MAX);
            case (state)
                IDLE: begin
                    if (Start) begin
                        state        <= FETCH;
                        pc           <= Start_Addr;
                        fetch_vld_p0 <= 1'b1;
                        Busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    if (last_hit) begin
                        // younger fetches in flight are squashed, PC holds
                        state        <= DRAIN;
                        fetch_vld_p0 <= 1'b0;
                        fetch_vld_p1 <= 1'b0;
                    end else if (fetch_vld_p0) begin
                        if (pc != PC_MAX) begin
                            pc <= pc + 1'b1;
                        end else begin
                            fetch_vld_p0 <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (wb_last_dl[ALU_LAT-1]) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decode: capture valid words and drive the data-memory read addresses.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            dec_vld_p2  <= 1'b0;
            dec_wb_p2   <= 1'b0;
            dec_last_p2 <= 1'b0;
            dec_op_p2   <= '0;
            dec_dst_p2  <= '0;
            Rd_Addr0    <= '0;
            Rd_Addr1    <= '0;
            Rd_Addr2    <= '0;
        end else begin
            dec_vld_p2  <= word_vld;
            dec_last_p2 <= last_hit;
            if (word_vld) begin
                dec_op_p2  <= word_op;
                dec_wb_p2  <= word_wb;
                dec_dst_p2 <= word_dst;
                Rd_Addr0   <= word_src0;
                Rd_Addr1   <= word_src1;
                Rd_Addr2   <= word_src2;
            end
        end
    end

    // Issue: opcode reaches the ALU together with the operands read last cycle.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            OP_Sel      <= '0;
            iss_vld_p3  <= 1'b0;
            iss_wb_p3   <= 1'b0;
            iss_last_p3 <= 1'b0;
            iss_dst_p3  <= '0;
        end else begin
            OP_Sel      <= dec_vld_p2 ? dec_op_p2 : 4'd0;
            iss_vld_p3  <= dec_vld_p2;
            iss_wb_p3   <= dec_vld_p2 && dec_wb_p2;
            iss_last_p3 <= dec_last_p2;
            iss_dst_p3  <= dec_dst_p2;
        end
    end

    // Write-back delay line: matches the ALU latency so Wr_En meets Data_Out.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wb_en_dl   <= '0;
            wb_last_dl <= '0;
            for (int i = 0; i < ALU_LAT; i++) begin
                wb_dst_dl[i] <= '0;
            end
        end else begin
            wb_en_dl[0]   <= iss_vld_p3 && iss_wb_p3;
            wb_last_dl[0] <= iss_vld_p3 && iss_last_p3;
            wb_dst_dl[0]  <= iss_dst_p3;
            for (int i = 1; i < ALU_LAT; i++) begin
                wb_en_dl[i]   <= wb_en_dl[i-1];
                wb_last_dl[i] <= wb_last_dl[i-1];
                wb_dst_dl[i]  <= wb_dst_dl[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Directed bench for pe_inst_sequencer: a behavioural synchronous instruction
// RAM, a table of expected output values per run and cycle, and hand-written
// sequences for reset behaviour.
module tb_pe_inst_sequencer;

    localparam int INST_AW = 10;
    localparam int DAW     = 8;
    localparam int ALU_LAT = 8;
    localparam int IW      = 4*DAW + 6;

    logic               Clk;
    logic               Resetn;
    logic               Start;
    logic [INST_AW-1:0] Start_Addr;
    logic               Busy;
    logic               Done;
    logic [INST_AW-1:0] Inst_Addr;
    logic [IW-1:0]      Inst_Data;
    logic [DAW-1:0]     Rd_Addr0;
    logic [DAW-1:0]     Rd_Addr1;
    logic [DAW-1:0]     Rd_Addr2;
    logic [3:0]         OP_Sel;
    logic               Wr_En;
    logic [DAW-1:0]     Wr_Addr;

    logic [IW-1:0] imem [1024];

    int nchk = 0;
    int nerr = 0;

    typedef enum {F_IADDR, F_RD0, F_RD1, F_RD2, F_OP, F_WE, F_WA, F_BUSY, F_DONE} field_e;

    typedef struct {
        int     tid;
        int     k;
        field_e f;
        int     val;
    } vec_t;

    vec_t vecs[$];

    pe_inst_sequencer #(.INST_AW(INST_AW), .DAW(DAW), .ALU_LAT(ALU_LAT)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Start_Addr(Start_Addr),
        .Busy(Busy), .Done(Done), .Inst_Addr(Inst_Addr), .Inst_Data(Inst_Data),
        .Rd_Addr0(Rd_Addr0), .Rd_Addr1(Rd_Addr1), .Rd_Addr2(Rd_Addr2),
        .OP_Sel(OP_Sel), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // synchronous instruction RAM, one cycle read latency
    always @(posedge Clk) Inst_Data <= imem[Inst_Addr];

    function automatic logic [IW-1:0] mk(int op, int s0, int s1, int s2, int dst, int wb, int last);
        return {1'(last), 1'(wb), DAW'(dst), DAW'(s2), DAW'(s1), DAW'(s0), 4'(op)};
    endfunction

    function automatic int fld(field_e f);
        case (f)
            F_IADDR: return int'(Inst_Addr);
            F_RD0:   return int'(Rd_Addr0);
            F_RD1:   return int'(Rd_Addr1);
            F_RD2:   return int'(Rd_Addr2);
            F_OP:    return int'(OP_Sel);
            F_WE:    return int'(Wr_En);
            F_WA:    return int'(Wr_Addr);
            F_BUSY:  return int'(Busy);
            F_DONE:  return int'(Done);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(int tid, int k, field_e f, int val);
        vecs.push_back('{tid, k, f, val});
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start a program at addr (sampled at the next edge, E0) and run ncyc cycles,
    // sampling after each edge; optional extra Start pulses at given cycles.
    task automatic run(input int tid, input int addr, input int ncyc,
                       input int inj_k1, input int inj_a1, input int inj_k2, input int inj_a2,
                       input int exp_we, input int exp_done);
        int we_n;
        int dn_n;
        we_n = 0;
        dn_n = 0;
        Start      = 1'b1;
        Start_Addr = INST_AW'(addr);
        for (int k = 0; k < ncyc; k++) begin
            step();
            Start = 1'b0;
            if (k == inj_k1) begin Start = 1'b1; Start_Addr = INST_AW'(inj_a1); end
            if (k == inj_k2) begin Start = 1'b1; Start_Addr = INST_AW'(inj_a2); end
            we_n += int'(Wr_En);
            dn_n += int'(Done);
            foreach (vecs[i]) begin
                if (vecs[i].tid == tid && vecs[i].k == k)
                    chk($sformatf("t%0d k%0d %s", tid, k, vecs[i].f.name()), fld(vecs[i].f), vecs[i].val);
            end
        end
        Start = 1'b0;
        chk($sformatf("t%0d wr_en_count", tid), we_n, exp_we);
        chk($sformatf("t%0d done_count", tid), dn_n, exp_done);
    endtask

    initial begin
        int we_n;
        int dn_n;

        for (int i = 0; i < 1024; i++) imem[i] = '0;
        // test 1: single ADD
        imem[5]    = mk(0, 1, 2, 3, 9, 1, 1);
        // test 2: three instructions, two younger words that must be squashed
        imem[20]   = mk(0, 3, 4, 0, 30, 1, 0);
        imem[21]   = mk(2, 5, 6, 0, 31, 1, 0);
        imem[22]   = mk(3, 7, 8, 0, 32, 1, 1);
        imem[23]   = mk(5, 9, 9, 0, 33, 1, 0);
        imem[24]   = mk(6, 9, 9, 0, 34, 1, 0);
        // test 3: middle instruction without write-back
        imem[40]   = mk(1, 10, 0, 0, 50, 1, 0);
        imem[41]   = mk(4, 11, 0, 0, 51, 0, 0);
        imem[42]   = mk(7, 12, 0, 0, 52, 1, 1);
        // test 4: single instruction, plus a decoy target for an ignored Start
        imem[60]   = mk(9, 13, 0, 0, 61, 1, 1);
        imem[100]  = mk(8, 0, 0, 0, 99, 1, 1);
        // test 6: top address without last bit; address 0 would show a wrap
        imem[1023] = mk(5, 14, 0, 0, 70, 1, 0);
        imem[0]    = mk(6, 15, 0, 0, 71, 1, 1);

        add(1, 0, F_IADDR, 5);  add(1, 0, F_BUSY, 1);  add(1, 0, F_DONE, 0);
        add(1, 1, F_IADDR, 6);  add(1, 1, F_RD0, 0);
        add(1, 2, F_RD0, 1);    add(1, 2, F_RD1, 2);   add(1, 2, F_RD2, 3);  add(1, 2, F_IADDR, 6);
        add(1, 3, F_OP, 0);
        add(1, 10, F_WE, 0);
        add(1, 11, F_WE, 1);    add(1, 11, F_WA, 9);   add(1, 11, F_BUSY, 1);
        add(1, 12, F_WE, 0);    add(1, 12, F_DONE, 1); add(1, 12, F_BUSY, 0);
        add(1, 13, F_DONE, 0);

        add(2, 2, F_RD0, 3);
        add(2, 3, F_RD0, 5);    add(2, 3, F_OP, 0);
        add(2, 4, F_RD0, 7);    add(2, 4, F_RD1, 8);   add(2, 4, F_OP, 2);   add(2, 4, F_IADDR, 23);
        add(2, 5, F_OP, 3);     add(2, 5, F_RD0, 7);
        add(2, 6, F_OP, 0);     add(2, 6, F_IADDR, 23);
        add(2, 11, F_WE, 1);    add(2, 11, F_WA, 30);
        add(2, 12, F_WE, 1);    add(2, 12, F_WA, 31);
        add(2, 13, F_WE, 1);    add(2, 13, F_WA, 32);  add(2, 13, F_DONE, 0);
        add(2, 14, F_WE, 0);    add(2, 14, F_DONE, 1); add(2, 14, F_BUSY, 0);

        add(3, 3, F_OP, 1);     add(3, 4, F_OP, 4);    add(3, 5, F_OP, 7);
        add(3, 11, F_WE, 1);    add(3, 11, F_WA, 50);
        add(3, 12, F_WE, 0);
        add(3, 13, F_WE, 1);    add(3, 13, F_WA, 52);  add(3, 13, F_DONE, 0);
        add(3, 14, F_DONE, 1);

        add(4, 4, F_IADDR, 61);
        add(4, 5, F_IADDR, 61); add(4, 5, F_BUSY, 1);
        add(4, 12, F_DONE, 1);  add(4, 12, F_BUSY, 0);
        add(4, 13, F_IADDR, 60); add(4, 13, F_BUSY, 1); add(4, 13, F_DONE, 0);
        add(4, 24, F_WE, 1);    add(4, 24, F_WA, 61);
        add(4, 25, F_DONE, 1);

        add(6, 0, F_IADDR, 1023); add(6, 1, F_IADDR, 1023);
        add(6, 2, F_RD0, 14);
        add(6, 3, F_OP, 5);     add(6, 4, F_OP, 0);
        add(6, 11, F_WE, 1);    add(6, 11, F_WA, 70);
        add(6, 12, F_DONE, 1);  add(6, 12, F_WE, 0);
        add(6, 14, F_IADDR, 1023);

        // reset
        Start      = 1'b0;
        Start_Addr = '0;
        Resetn     = 1'b1;
        #3 Resetn  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset Busy", int'(Busy), 0);
        chk("reset Done", int'(Done), 0);
        chk("reset Inst_Addr", int'(Inst_Addr), 0);
        chk("reset Rd_Addr0", int'(Rd_Addr0), 0);
        chk("reset OP_Sel", int'(OP_Sel), 0);
        chk("reset Wr_En", int'(Wr_En), 0);
        chk("reset Wr_Addr", int'(Wr_Addr), 0);
        @(negedge Clk) Resetn = 1'b1;
        step();

        run(1, 5, 15, -1, 0, -1, 0, 1, 1);
        run(2, 20, 17, -1, 0, -1, 0, 3, 1);
        run(3, 40, 17, -1, 0, -1, 0, 2, 1);
        run(4, 60, 28, 3, 100, 12, 60, 2, 2);
        run(6, 1023, 16, -1, 0, -1, 0, 1, 1);

        // test 5: asynchronous reset while draining the single-ADD program
        Start      = 1'b1;
        Start_Addr = 10'd5;
        step();
        Start = 1'b0;
        repeat (5) step();
        chk("t5 pre-reset Busy", int'(Busy), 1);
        chk("t5 pre-reset Rd_Addr0", int'(Rd_Addr0), 1);
        #1 Resetn = 1'b0;
        #1;
        chk("t5 async Busy", int'(Busy), 0);
        chk("t5 async Inst_Addr", int'(Inst_Addr), 0);
        chk("t5 async Rd_Addr0", int'(Rd_Addr0), 0);
        chk("t5 async Rd_Addr1", int'(Rd_Addr1), 0);
        chk("t5 async OP_Sel", int'(OP_Sel), 0);
        chk("t5 async Wr_En", int'(Wr_En), 0);
        chk("t5 async Done", int'(Done), 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) Resetn = 1'b1;
        step();
        we_n = 0;
        dn_n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            we_n += int'(Wr_En);
            dn_n += int'(Done);
        end
        chk("t5 post-reset wr_en_count", we_n, 0);
        chk("t5 post-reset done_count", dn_n, 0);
        run(1, 5, 15, -1, 0, -1, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
